// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and its update rule.
package branch_predictor_pkg;

  localparam int unsigned BP_IDX_BITS = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Saturating step toward taken (+1) or not-taken (-1).
  function automatic bp_ctr_t ctr_update(input bp_ctr_t c, input logic taken);
    bp_ctr_t n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor bus: IF lookup, EX resolution and statistics.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_next_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_next_pc,
    input  pred_taken, pred_next_pc, mispredict, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken, ex_pred_next_pc,
    output pred_taken, pred_next_pc, mispredict, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped BTB storage: combinational reads for IF lookup and EX update, one sync write.
module bp_table #(
  parameter int unsigned             IDX_BITS  = 6,
  parameter int unsigned             W         = 64,
  parameter logic        [W-1:0]     RST_ENTRY = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] if_idx,
  output logic [W-1:0]        if_entry,
  input  logic [IDX_BITS-1:0] ex_idx,
  output logic [W-1:0]        ex_entry,
  input  logic                we,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [W-1:0]        wr_entry
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  logic [W-1:0] mem [DEPTH];

  // Reads see the pre-write contents; a same-cycle write shows up next cycle.
  assign if_entry = mem[if_idx];
  assign ex_entry = mem[ex_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
    end else if (we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB with 2-bit direction counters: IF next-PC prediction, EX mispredict/redirect and stats.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = BP_IDX_BITS
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned TAG_BITS = 30 - IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    bp_ctr_t             ctr;
  } bp_entry_t;

  localparam int unsigned ENTRY_W = $bits(bp_entry_t);
  localparam bp_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [ENTRY_W-1:0]  if_raw, ex_raw, wr_raw;
  bp_entry_t           if_ent, ex_ent, wr_ent;
  logic                if_hit, ex_hit, we;
  logic [31:0]         br_cnt, mp_cnt;
  logic                unused_pc_lsbs;

  assign if_idx = bp.if_pc[IDX_BITS+1:2];
  assign if_tag = bp.if_pc[31:IDX_BITS+2];
  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bp.ex_pc[31:IDX_BITS+2];
  assign unused_pc_lsbs = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

  bp_table #(
    .IDX_BITS (IDX_BITS),
    .W        (ENTRY_W),
    .RST_ENTRY(RST_ENTRY)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .if_idx  (if_idx),
    .if_entry(if_raw),
    .ex_idx  (ex_idx),
    .ex_entry(ex_raw),
    .we      (we),
    .wr_idx  (ex_idx),
    .wr_entry(wr_raw)
  );

  assign if_ent = bp_entry_t'(if_raw);
  assign ex_ent = bp_entry_t'(ex_raw);
  assign wr_raw = ENTRY_W'(wr_ent);

  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  assign bp.pred_taken   = if_hit && if_ent.ctr[1];
  assign bp.pred_next_pc = bp.pred_taken ? if_ent.target : bp.if_pc + 32'd4;

  assign bp.mispredict  = bp.ex_valid &&
                          ((bp.ex_taken != bp.ex_pred_taken) ||
                           (bp.ex_taken && (bp.ex_pred_next_pc != bp.ex_target)));
  assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;

  // Hits always train the counter; misses allocate only when taken.
  always_comb begin
    wr_ent = ex_ent;
    we     = 1'b0;
    if (bp.ex_valid) begin
      if (ex_hit) begin
        we         = 1'b1;
        wr_ent.ctr = ctr_update(ex_ent.ctr, bp.ex_taken);
        if (bp.ex_taken) wr_ent.target = bp.ex_target;
      end else if (bp.ex_taken) begin
        we     = 1'b1;
        wr_ent = '{valid: 1'b1, tag: ex_tag, target: bp.ex_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (bp.ex_valid)   br_cnt <= br_cnt + 32'd1;
      if (bp.mispredict) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign bp.br_count      = br_cnt;
  assign bp.mispred_count = mp_cnt;

endmodule
